// File: rtl/sprite_plot_sequencer.sv
// Turns one (x, y, colour) anchor update into a per-pixel plot stream: erase the previous
// sprite box to background, then draw the new box, one pixel slot per clock.
module sprite_plot_sequencer #(
    parameter int unsigned SPRITE_W  = 4,
    parameter int unsigned SPRITE_H  = 4,
    parameter int unsigned SCREEN_W  = 320,
    parameter int unsigned SCREEN_H  = 240,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] in_x,
    input  logic [7:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       draw_done
);

    localparam logic [3:0] LastDx = 4'(SPRITE_W - 1);
    localparam logic [3:0] LastDy = 4'(SPRITE_H - 1);

    typedef enum logic [1:0] {StIdle, StErase, StDraw} state_e;

    state_e     r_state, w_state;
    logic [3:0] r_dx, w_dx, r_dy, w_dy;
    logic       r_has_prev, w_has_prev;
    logic [8:0] r_prev_x, w_prev_x, r_new_x, w_new_x;
    logic [7:0] r_prev_y, w_prev_y, r_new_y, w_new_y;
    logic [2:0] r_prev_colour, w_prev_colour, r_new_colour, w_new_colour;
    logic [8:0] r_vga_x, w_vga_x;
    logic [7:0] r_vga_y, w_vga_y;
    logic [2:0] r_vga_colour, w_vga_colour;
    logic       r_vga_plot, w_vga_plot;
    logic       r_draw_done, w_draw_done;

    logic       w_emit, w_erase_slot, w_last, w_same;
    logic [3:0] w_adv_dx, w_adv_dy;
    logic [8:0] w_base_x;
    logic [7:0] w_base_y;
    logic [2:0] w_base_colour;
    logic [9:0] w_sum_x;
    logic [8:0] w_sum_y;

    // r_dx/r_dy index the slot currently on the outputs; the state names its sweep.
    assign w_last   = (r_dx == LastDx) && (r_dy == LastDy);
    assign w_adv_dx = (r_dx == LastDx) ? 4'd0 : r_dx + 4'd1;
    assign w_adv_dy = (r_dx == LastDx) ? r_dy + 4'd1 : r_dy;
    assign w_same   = (in_x == r_prev_x) && (in_y == r_prev_y) && (in_colour == r_prev_colour);

    assign in_ready   = (r_state == StIdle) && !reset;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;
    assign draw_done  = r_draw_done;

    always_comb begin
        w_state       = r_state;
        w_dx          = r_dx;
        w_dy          = r_dy;
        w_has_prev    = r_has_prev;
        w_prev_x      = r_prev_x;
        w_prev_y      = r_prev_y;
        w_prev_colour = r_prev_colour;
        w_new_x       = r_new_x;
        w_new_y       = r_new_y;
        w_new_colour  = r_new_colour;
        w_emit        = 1'b0;
        w_erase_slot  = 1'b0;
        w_draw_done   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_new_x      = in_x;
                    w_new_y      = in_y;
                    w_new_colour = in_colour;
                    if (r_has_prev && w_same) begin
                        w_draw_done = 1'b1;
                    end else begin
                        w_emit       = 1'b1;
                        w_dx         = 4'd0;
                        w_dy         = 4'd0;
                        w_erase_slot = r_has_prev;
                        w_state      = r_has_prev ? StErase : StDraw;
                    end
                end
            end
            StErase: begin
                w_emit = 1'b1;
                if (w_last) begin
                    w_state = StDraw;
                    w_dx    = 4'd0;
                    w_dy    = 4'd0;
                end else begin
                    w_dx         = w_adv_dx;
                    w_dy         = w_adv_dy;
                    w_erase_slot = 1'b1;
                end
            end
            StDraw: begin
                // The last draw pixel stays visible for one cycle before returning to idle.
                if (w_last) begin
                    w_state = StIdle;
                end else begin
                    w_emit = 1'b1;
                    w_dx   = w_adv_dx;
                    w_dy   = w_adv_dy;
                end
            end
            default: w_state = StIdle;
        endcase

        w_base_x      = w_erase_slot ? r_prev_x : w_new_x;
        w_base_y      = w_erase_slot ? r_prev_y : w_new_y;
        w_base_colour = w_erase_slot ? BG_COLOUR : w_new_colour;
        w_sum_x       = {1'b0, w_base_x} + {6'd0, w_dx};
        w_sum_y       = {1'b0, w_base_y} + {5'd0, w_dy};

        w_vga_x      = r_vga_x;
        w_vga_y      = r_vga_y;
        w_vga_colour = r_vga_colour;
        w_vga_plot   = 1'b0;
        if (w_emit) begin
            w_vga_x      = w_sum_x[8:0];
            w_vga_y      = w_sum_y[7:0];
            w_vga_colour = w_base_colour;
            w_vga_plot   = (32'(w_sum_x) < SCREEN_W) && (32'(w_sum_y) < SCREEN_H);
            if (!w_erase_slot && (w_dx == LastDx) && (w_dy == LastDy)) begin
                w_draw_done   = 1'b1;
                w_has_prev    = 1'b1;
                w_prev_x      = w_new_x;
                w_prev_y      = w_new_y;
                w_prev_colour = w_new_colour;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_dx          <= 4'd0;
            r_dy          <= 4'd0;
            r_has_prev    <= 1'b0;
            r_prev_x      <= 9'd0;
            r_prev_y      <= 8'd0;
            r_prev_colour <= 3'd0;
            r_new_x       <= 9'd0;
            r_new_y       <= 8'd0;
            r_new_colour  <= 3'd0;
            r_vga_x       <= 9'd0;
            r_vga_y       <= 8'd0;
            r_vga_colour  <= 3'd0;
            r_vga_plot    <= 1'b0;
            r_draw_done   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_dx          <= w_dx;
            r_dy          <= w_dy;
            r_has_prev    <= w_has_prev;
            r_prev_x      <= w_prev_x;
            r_prev_y      <= w_prev_y;
            r_prev_colour <= w_prev_colour;
            r_new_x       <= w_new_x;
            r_new_y       <= w_new_y;
            r_new_colour  <= w_new_colour;
            r_vga_x       <= w_vga_x;
            r_vga_y       <= w_vga_y;
            r_vga_colour  <= w_vga_colour;
            r_vga_plot    <= w_vga_plot;
            r_draw_done   <= w_draw_done;
        end
    end

endmodule

// File: tb/tb_sprite_plot_sequencer.sv
// Bench for sprite_plot_sequencer: a queue-based model of expected per-cycle outputs,
// directed boundary scenarios with literal expectations, then randomized updates.
module tb_sprite_plot_sequencer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int SW = 320;
    localparam int SH = 240;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] in_x = 9'd0;
    logic [7:0] in_y = 8'd0;
    logic [2:0] in_colour = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       draw_done;

    always #5 clk = ~clk;

    sprite_plot_sequencer #(
        .SPRITE_W (W),
        .SPRITE_H (H),
        .SCREEN_W (SW),
        .SCREEN_H (SH),
        .BG_COLOUR(3'b000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_colour (in_colour),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .draw_done (draw_done)
    );

    int errors = 0;
    int checks = 0;
    int plot_cnt = 0;

    typedef struct packed {
        logic       rdy;
        logic       plot;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       done;
    } ent_t;

    // One entry per future cycle: what the outputs must show in that cycle.
    ent_t exp_q[$];
    bit         m_has_prev = 1'b0;
    logic [8:0] m_px = 9'd0;
    logic [7:0] m_py = 8'd0;
    logic [2:0] m_pc = 3'd0;

    logic [8:0] last_x = 9'd0;
    logic [7:0] last_y = 8'd0;
    logic [2:0] last_c = 3'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_box(input int bx, input int by, input logic [2:0] c,
                                     input bit is_draw);
        ent_t e;
        for (int j = 0; j < H; j++) begin
            for (int i = 0; i < W; i++) begin
                int sx = bx + i;
                int sy = by + j;
                e.rdy  = 1'b0;
                e.plot = (sx < SW) && (sy < SH);
                e.x    = 9'(sx);
                e.y    = 8'(sy);
                e.c    = c;
                e.done = is_draw && (i == W - 1) && (j == H - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void model_accept(input logic [8:0] x, input logic [7:0] y,
                                         input logic [2:0] c);
        ent_t e;
        if (m_has_prev && x == m_px && y == m_py && c == m_pc) begin
            e = '0;
            e.rdy = 1'b1;
            e.done = 1'b1;
            exp_q.push_back(e);
        end else begin
            if (m_has_prev) push_box(int'(m_px), int'(m_py), 3'b000, 1'b0);
            push_box(int'(x), int'(y), c, 1'b1);
            m_has_prev = 1'b1;
            m_px = x;
            m_py = y;
            m_pc = c;
        end
    endfunction

    always @(posedge clk) begin
        bit rdy_now;
        if (reset) begin
            exp_q.delete();
            m_has_prev = 1'b0;
        end else begin
            rdy_now = (exp_q.size() == 0) || exp_q[0].rdy;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && rdy_now) model_accept(in_x, in_y, in_colour);
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (vga_plot === 1'b1) plot_cnt++;
        if (reset) begin
            chk("ready_in_reset", int'(in_ready), 0);
        end else begin
            e = '0;
            e.rdy = 1'b1;
            if (exp_q.size() != 0) e = exp_q[0];
            checks++;
            if (in_ready !== e.rdy || vga_plot !== e.plot || draw_done !== e.done ||
                (e.plot && (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c))) begin
                errors++;
                $display("FAIL cycle_compare @%0t: got rdy=%b plot=%b done=%b x=%0d y=%0d c=%0d required rdy=%b plot=%b done=%b x=%0d y=%0d c=%0d",
                         $time, in_ready, vga_plot, draw_done, vga_x, vga_y, vga_colour,
                         e.rdy, e.plot, e.done, e.x, e.y, e.c);
            end
        end
    end

    task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c,
                        input bit jitter);
        int n = 0;
        @(negedge clk);
        in_x = x;
        in_y = y;
        in_colour = c;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
            if (jitter) begin
                in_x = 9'($urandom_range(30, 300));
                in_y = 8'($urandom_range(30, 200));
                in_colour = 3'($urandom_range(0, 7));
            end
        end
        if (n >= 200) chk("accept_timeout", n, 0);
        last_x = in_x;
        last_y = in_y;
        last_c = in_colour;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic measure(output int rdy_k, output int done_k, output int plots);
        int p0 = plot_cnt;
        rdy_k = 0;
        done_k = 0;
        do begin
            @(negedge clk);
            rdy_k++;
            if (draw_done === 1'b1 && done_k == 0) done_k = rdy_k;
        end while (in_ready !== 1'b1 && rdy_k < 500);
        if (rdy_k >= 500) chk("ready_timeout", rdy_k, 0);
        #1 plots = plot_cnt - p0;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rk, dk, pk, mode;
        logic [8:0] rx;
        logic [7:0] ry;
        logic [2:0] rc;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_vga_colour", int'(vga_colour), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_done", int'(draw_done), 0);
        chk("rst_ready", int'(in_ready), 1);

        send(9'd100, 8'd50, 3'b101, 1'b0);
        chk("t1_first_x", int'(vga_x), 100);
        chk("t1_first_y", int'(vga_y), 50);
        chk("t1_first_c", int'(vga_colour), 5);
        chk("t1_first_plot", int'(vga_plot), 1);
        measure(rk, dk, pk);
        chk("t1_ready_at", rk, 17);
        chk("t1_done_at", dk, 16);
        chk("t1_plots", pk, 16);

        send(9'd104, 8'd50, 3'b010, 1'b0);
        chk("t2_erase_x", int'(vga_x), 100);
        chk("t2_erase_c", int'(vga_colour), 0);
        measure(rk, dk, pk);
        chk("t2_ready_at", rk, 33);
        chk("t2_done_at", dk, 32);
        chk("t2_plots", pk, 32);

        send(9'd104, 8'd50, 3'b010, 1'b0);
        measure(rk, dk, pk);
        chk("t3_ready_at", rk, 1);
        chk("t3_done_at", dk, 1);
        chk("t3_plots", pk, 0);

        reset_pulse();
        send(9'd318, 8'd238, 3'b111, 1'b0);
        measure(rk, dk, pk);
        chk("t4_edge_ready_at", rk, 17);
        chk("t4_edge_plots", pk, 4);

        reset_pulse();
        send(9'd511, 8'd255, 3'b111, 1'b0);
        measure(rk, dk, pk);
        chk("t4_far_ready_at", rk, 17);
        chk("t4_far_done_at", dk, 16);
        chk("t4_far_plots", pk, 0);

        send(9'd20, 8'd20, 3'b001, 1'b0);
        send(9'd40, 8'd40, 3'b011, 1'b1);
        measure(rk, dk, pk);
        chk("t5_ready_at", rk, 33);
        chk("t5_plots", pk, 32);

        reset_pulse();
        send(9'd40, 8'd40, 3'b011, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("t6_plot_after_reset", int'(vga_plot), 0);
        reset = 1'b0;
        #1 chk("t6_ready_after_release", int'(in_ready), 1);
        send(9'd40, 8'd40, 3'b011, 1'b0);
        measure(rk, dk, pk);
        chk("t6_ready_at", rk, 17);
        chk("t6_plots", pk, 16);

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 9));
            rc = 3'($urandom_range(0, 7));
            if (mode < 2) begin
                rx = last_x;
                ry = last_y;
                rc = last_c;
            end else if (mode < 5) begin
                rx = 9'($urandom_range(300, 511));
                ry = 8'($urandom_range(220, 255));
            end else begin
                rx = 9'($urandom_range(0, 319));
                ry = 8'($urandom_range(0, 239));
            end
            send(rx, ry, rc, ($urandom_range(0, 4) == 0));
            mode = int'($urandom_range(0, 7));
            if (mode == 0) begin
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end else if (mode < 6) begin
                measure(rk, dk, pk);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        measure(rk, dk, pk);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
